// File: rtl/gpu_host_arbiter.sv
// Round-robin arbiter for the GPU RAM/palette host port with lock support.
// Reads return in order through a fixed-latency {valid, id} shift.
module gpu_host_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int READ_LATENCY = 2,
  parameter int MAX_LOCK     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_wr,
  input  logic [NUM_REQ-1:0]   req_lock,
  input  logic [NUM_REQ*20-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rd_valid,
  output logic [7:0]           rd_data,
  output logic                 lock_timeout,
  output logic                 host_wr_ena,
  output logic [19:0]          host_addr,
  output logic [7:0]           host_wr_data,
  input  logic [7:0]           host_rd_data
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RL  = READ_LATENCY;

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t                  r_state;
  logic [IDW-1:0]          r_last;
  logic [IDW-1:0]          r_owner;
  logic [7:0]              r_lock_cnt;
  logic                    r_timeout;
  logic                    r_wr_ena;
  logic [19:0]             r_addr;
  logic [7:0]              r_wdata;
  logic [NUM_REQ-1:0]      r_rd_valid;
  logic [7:0]              r_rd_data;
  logic [RL:0]             r_sh_v;
  logic [RL:0][IDW-1:0]    r_sh_id;

  int                      w_idx;
  logic                    w_rr_hit;
  logic [IDW-1:0]          w_rr_id;
  logic [IDW-1:0]          w_gnt_id;
  logic [NUM_REQ-1:0]      w_ready;
  logic                    w_xfer;
  logic                    w_is_rd;
  logic [7:0]              w_cnt_inc;
  logic                    w_cnt_max;
  logic [NUM_REQ-1:0]      w_rd_oh;

  // Descending scan so the nearest requester after r_last wins.
  always_comb begin
    w_idx    = 0;
    w_rr_hit = 1'b0;
    w_rr_id  = r_last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (req_valid[w_idx]) begin
        w_rr_hit = 1'b1;
        w_rr_id  = IDW'(w_idx);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (!reset) begin
      case (r_state)
        ST_LOCKED: w_ready[r_owner] = req_valid[r_owner];
        default:   w_ready[w_rr_id] = w_rr_hit;
      endcase
    end
  end

  assign w_gnt_id  = (r_state == ST_LOCKED) ? r_owner : w_rr_id;
  assign w_xfer    = |w_ready;
  assign w_is_rd   = w_xfer & ~req_wr[w_gnt_id];
  assign w_cnt_inc = (r_lock_cnt < 8'(MAX_LOCK)) ? r_lock_cnt + 8'd1
                                                  : r_lock_cnt;
  assign w_cnt_max = (w_cnt_inc >= 8'(MAX_LOCK));

  always_comb begin
    w_rd_oh = '0;
    w_rd_oh[r_sh_id[RL]] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_ARB;
      r_last     <= IDW'(NUM_REQ - 1);
      r_owner    <= '0;
      r_lock_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_xfer) begin
        r_last <= w_gnt_id;
        case (r_state)
          ST_ARB: begin
            if (req_lock[w_gnt_id]) begin
              r_state    <= ST_LOCKED;
              r_owner    <= w_gnt_id;
              r_lock_cnt <= 8'd1;
            end
          end
          default: begin
            r_lock_cnt <= w_cnt_inc;
            if (w_cnt_max) begin
              r_state   <= ST_ARB;
              r_timeout <= 1'b1;
            end else if (!req_lock[r_owner]) begin
              r_state <= ST_ARB;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ena   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_sh_v     <= '0;
      r_sh_id    <= '0;
      r_rd_valid <= '0;
      r_rd_data  <= '0;
    end else begin
      r_wr_ena <= 1'b0;
      if (w_xfer) begin
        r_wr_ena <= req_wr[w_gnt_id];
        r_addr   <= req_addr[int'(w_gnt_id)*20 +: 20];
        r_wdata  <= req_wdata[int'(w_gnt_id)*8 +: 8];
      end
      r_sh_v     <= {r_sh_v[RL-1:0], w_is_rd};
      r_sh_id    <= {r_sh_id[RL-1:0], w_gnt_id};
      r_rd_valid <= r_sh_v[RL] ? w_rd_oh : '0;
      if (r_sh_v[RL])
        r_rd_data <= host_rd_data;
    end
  end

  assign req_ready    = w_ready;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign lock_timeout = r_timeout;
  assign host_wr_ena  = r_wr_ena;
  assign host_addr    = r_addr;
  assign host_wr_data = r_wdata;

endmodule

// File: tb/tb_gpu_host_arbiter.sv
// Directed bench for gpu_host_arbiter (NUM_REQ=3, READ_LATENCY=2, MAX_LOCK=16).
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_gpu_host_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_wr;
  logic [2:0]  req_lock;
  logic [59:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  req_ready;
  logic [2:0]  rd_valid;
  logic [7:0]  rd_data;
  logic        lock_timeout;
  logic        host_wr_ena;
  logic [19:0] host_addr;
  logic [7:0]  host_wr_data;
  logic [7:0]  host_rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign host_rd_data = 8'(cyc * 13 + 5);

  gpu_host_arbiter #(
    .NUM_REQ(3), .READ_LATENCY(2), .MAX_LOCK(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wr(req_wr), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .lock_timeout(lock_timeout), .host_wr_ena(host_wr_ena),
    .host_addr(host_addr), .host_wr_data(host_wr_data),
    .host_rd_data(host_rd_data)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    req_wr    = '0;
    req_lock  = '0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 3'b111;
    req_wr    = '0;
    req_lock  = '0;
    req_addr  = {20'h00032, 20'h00021, 20'h00010};
    req_wdata = 24'h332211;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready got %b want 000", req_ready);
    end
    checks++;
    if ({rd_valid, rd_data, lock_timeout} !== 12'h000) begin
      errors++; $display("FAIL reset_rd got %b/%h/%b want 0",
                         rd_valid, rd_data, lock_timeout);
    end
    checks++;
    if ({host_wr_ena, host_addr, host_wr_data} !== 29'h0) begin
      errors++; $display("FAIL reset_host got %b/%h/%h want 0",
                         host_wr_ena, host_addr, host_wr_data);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [2:0]  exp_rdy;
    logic [2:0]  exp_rv;
    logic [19:0] exp_addr;
    req_valid = 3'b111;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      exp_rdy = 3'b001 << (j % 3);
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_ready c%0d got %b want %b",
                           j, req_ready, exp_rdy);
      end
      exp_rv = (j >= 4) ? (3'b001 << ((j - 4) % 3)) : 3'b000;
      checks++;
      if (rd_valid !== exp_rv) begin
        errors++; $display("FAIL rr_rd_valid c%0d got %b want %b",
                           j, rd_valid, exp_rv);
      end
      if (j >= 1) begin
        exp_addr = 20'h00010 + 20'h11 * 20'((j - 1) % 3);
        checks++;
        if (host_addr !== exp_addr || host_wr_ena !== 1'b0) begin
          errors++; $display("FAIL rr_host c%0d got %h/%b want %h/0",
                             j, host_addr, host_wr_ena, exp_addr);
        end
      end
      next_cycle();
    end
    idle(5);
  endtask

  task automatic test_write;
    logic seen;
    req_addr[39:20] = 20'h07C00;
    req_wdata[15:8] = 8'hA5;
    req_valid = 3'b010;
    req_wr    = 3'b010;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL wr_ready got %b want 010", req_ready);
    end
    next_cycle();
    req_valid = '0;
    req_wr    = '0;
    @(negedge clk);
    checks++;
    if ({host_wr_ena, host_addr, host_wr_data} !== {1'b1, 20'h07C00, 8'hA5}) begin
      errors++; $display("FAIL wr_strobe got %b/%h/%h want 1/07c00/a5",
                         host_wr_ena, host_addr, host_wr_data);
    end
    seen = rd_valid != 0;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({host_wr_ena, host_addr} !== {1'b0, 20'h07C00}) begin
      errors++; $display("FAIL wr_hold got %b/%h want 0/07c00",
                         host_wr_ena, host_addr);
    end
    for (int i = 0; i < 5; i++) begin
      seen = seen | (rd_valid != 0);
      next_cycle();
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL wr_no_rd got %b want 0", seen);
    end
    next_cycle();
  endtask

  task automatic test_lock_rmw;
    logic [2:0] vals [4] = '{3'b101, 3'b001, 3'b101, 3'b001};
    logic [2:0] exps [4] = '{3'b100, 3'b000, 3'b100, 3'b001};
    for (int j = 0; j < 4; j++) begin
      req_valid = vals[j];
      req_lock  = (j == 0) ? 3'b100 : 3'b000;
      req_wr    = (j == 2) ? 3'b100 : 3'b000;
      @(negedge clk);
      checks++;
      if (req_ready !== exps[j]) begin
        errors++; $display("FAIL lock_ready c%0d got %b want %b",
                           j, req_ready, exps[j]);
      end
      next_cycle();
    end
    idle(1);
  endtask

  task automatic test_timeout;
    int         n0;
    logic [2:0] exp_rdy;
    n0 = 0;
    req_lock = 3'b001;
    req_wr   = '0;
    for (int j = 0; j < 18; j++) begin
      req_valid = (j == 0) ? 3'b001 : 3'b011;
      @(negedge clk);
      exp_rdy = (j < 16 || j == 17) ? 3'b001 : 3'b010;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL to_ready c%0d got %b want %b",
                           j, req_ready, exp_rdy);
      end
      checks++;
      if (lock_timeout !== (j == 16)) begin
        errors++; $display("FAIL to_pulse c%0d got %b want %b",
                           j, lock_timeout, j == 16);
      end
      if (j < 17 && req_ready[0]) n0++;
      next_cycle();
    end
    checks++;
    if (n0 !== 16) begin
      errors++; $display("FAIL to_count got %0d want 16", n0);
    end
  endtask

  task automatic test_reset_flight;
    logic seen;
    req_lock  = '0;
    req_wr    = '0;
    req_valid = 3'b001;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL rf_rd0 got %b want 001", req_ready);
    end
    next_cycle();
    req_valid = 3'b010;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL rf_rd1 got %b want 010", req_ready);
    end
    next_cycle();
    reset     = 1'b1;
    req_valid = 3'b111;
    @(negedge clk);
    checks++;
    if ({req_ready, rd_valid, rd_data, lock_timeout} !== 15'h0) begin
      errors++; $display("FAIL rf_rst_out got %b/%b/%h/%b want 0",
                         req_ready, rd_valid, rd_data, lock_timeout);
    end
    checks++;
    if ({host_wr_ena, host_addr, host_wr_data} !== 29'h0) begin
      errors++; $display("FAIL rf_rst_host got %b/%h/%h want 0",
                         host_wr_ena, host_addr, host_wr_data);
    end
    next_cycle();
    reset     = 1'b0;
    req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | (rd_valid != 0);
      next_cycle();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rf_no_rd got %b want 0", seen);
    end
  endtask

  task automatic test_rd_data;
    int         texp [4];
    logic [2:0] exp_rv;
    logic [7:0] exp_d;
    req_wr   = '0;
    req_lock = '0;
    for (int j = 0; j < 9; j++) begin
      req_valid = (j < 4) ? 3'b011 : 3'b000;
      @(negedge clk);
      if (j < 4) begin
        texp[j] = cyc + 1 + 2;
        exp_rv = (j % 2 == 0) ? 3'b001 : 3'b010;
        checks++;
        if (req_ready !== exp_rv) begin
          errors++; $display("FAIL rd_ready c%0d got %b want %b",
                             j, req_ready, exp_rv);
        end
      end
      exp_rv = (j >= 4 && j < 8) ? ((j % 2 == 0) ? 3'b001 : 3'b010) : 3'b000;
      checks++;
      if (rd_valid !== exp_rv) begin
        errors++; $display("FAIL rd_valid c%0d got %b want %b",
                           j, rd_valid, exp_rv);
      end
      if (j >= 4 && j < 8) begin
        exp_d = 8'(texp[j-4] * 13 + 5);
        checks++;
        if (rd_data !== exp_d) begin
          errors++; $display("FAIL rd_data c%0d got %h want %h",
                             j, rd_data, exp_d);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write();
    test_lock_rmw();
    test_timeout();
    test_reset_flight();
    test_rd_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
